serializer_rr_arbiter: RTL and testbench
========================================

Name: serializer_rr_arbiter

Overview:
- Round-robin arbiter that shares one serializer instance between NUM_REQ parallel-word requesters.
- Each requester uses a valid/ready handshake to transfer one word plus its data_mod into an internal holding register.
- The block issues that word to the serializer when the serializer is not busy, then waits for the serial burst to finish before granting again.
- It drops words whose data_mod the serializer does not support (1 and 2) and flags each drop.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_BUS_WIDTH, 16, word width; matches the serializer.
- DATA_MOD_WIDTH, 4, data_mod width; matches the serializer. data_mod 0 means a full word.
- TIMEOUT_CYC, 4, cycles allowed for ser_busy_i to rise after issue. Used only with SER_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- arst_ni  in  1  asynchronous reset, active-low.
- req_data_i  in  NUM_REQ*DATA_BUS_WIDTH  packed words; requester k occupies slice k.
- req_mod_i  in  NUM_REQ*DATA_MOD_WIDTH  packed data_mod values; requester k occupies slice k.
- req_val_i  in  NUM_REQ  per-requester valid; held until ready.
- req_ready_o  out  NUM_REQ  one-hot grant. A transfer occurs on val&ready at posedge.
- req_drop_o  out  NUM_REQ  one-cycle pulse, registered: the accepted word had data_mod 1 or 2 and was discarded.
- grant_idx_o  out  $clog2(NUM_REQ)  index of the requester owning the current transfer.
- active_o  out  1  high in every state except IDLE.
- ser_data_o  out  DATA_BUS_WIDTH  word to the serializer data_i.
- ser_mod_o  out  DATA_MOD_WIDTH  data_mod to the serializer data_mod_i.
- ser_val_o  out  1  to the serializer data_val_i.
- ser_busy_i  in  1  from the serializer busy_o.
- timeout_o  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro.

Behaviour:
Reset values:
- Reset is asynchronous, active-low. It forces state IDLE, rr_ptr = NUM_REQ-1, and clears the holding register and the timeout counter.
- All outputs are 0 in reset.

State machine (IDLE, ISSUE, WAIT_START, WAIT_END):
- IDLE
  - If ser_busy_i==0 and any req_val_i is set, the winner is the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle. No other ready is set.
  - At posedge, capture data/mod into the holding register, set grant_idx_o, and set rr_ptr=winner.
  - If the captured mod is 1 or 2: pulse req_drop_o[winner] next cycle and stay IDLE.
  - Otherwise go to ISSUE.
  - If ser_busy_i==1 in IDLE, no ready is asserted.
- ISSUE
  - ser_val_o=1; ser_data_o and ser_mod_o come from the holding register.
  - If ser_busy_i==0, go to WAIT_START at posedge; the serializer accepts on that edge.
  - If ser_busy_i==1, hold ser_val_o and stay in ISSUE.
- WAIT_START
  - ser_val_o=0. When ser_busy_i==1, go to WAIT_END.
- WAIT_END
  - When ser_busy_i==0, go to IDLE. A new grant is possible in that IDLE cycle.

Outputs:
- ser_data_o and ser_mod_o show the holding register in every state; they are 0 after reset.

Latency:
- Request to ser_val_o: 1 cycle.
- Serializer idle after burst to next ready: 1 cycle (the IDLE cycle).

Boundary conditions:
- Fairness: all requesters valid gives grants in order k+1, k+2, … with wrap; a requester never waits more than NUM_REQ-1 grants.
- A requester deasserting val before ready is not granted; no state is kept.
- Reset asserted mid-burst returns the block to IDLE immediately, abandoning the word.
- NUM_REQ not a power of 2: wrap skips the unused indices.
- Without the macro, WAIT_START waits indefinitely.

Optional Feature:
SER_ARB_TIMEOUT_EN
- With the macro: a counter runs in WAIT_START.
  - If ser_busy_i has not risen after TIMEOUT_CYC cycles, go to IDLE and pulse timeout_o for one cycle.
  - The word is lost and rr_ptr is kept.
  - The counter clears on entry to WAIT_START.
- Without the macro: there is no counter, and timeout_o is constant 0.

Test Plan:
1. Reset then single request: req_val_i=4'b0010, data 16'hA5C3, mod 0 → req_ready_o=4'b0010 for 1 cycle. Next cycle ser_val_o=1 with ser_data_o=16'hA5C3, then WAIT_START → WAIT_END, active_o falls 1 cycle after busy falls.
2. All four valid continuously with a serializer model → grant order 0,1,2,3,0. Each word reaches ser_data_o intact; no grant occurs while ser_busy_i=1.
3. Requester 2 with mod 4'd1, requester 3 with mod 4'd0 → req_drop_o=4'b0100 pulse, ser_val_o stays 0. Requester 3 is granted on the following IDLE cycle.
4. ser_busy_i forced 1 when ISSUE is entered → ser_val_o held high until busy is 0, then a single accept.
5. Reset asserted during WAIT_END, data 16'hFFFF mod 0 → all outputs 0 immediately. After release, a fresh request on requester 0 is granted first (rr_ptr=NUM_REQ-1).
6. SER_ARB_TIMEOUT_EN with TIMEOUT_CYC=4 and ser_busy_i stuck 0 → timeout_o pulses 4 cycles after WAIT_START entry and the block returns to IDLE. Without the macro it stays in WAIT_START and timeout_o stays 0.

Source files
------------

// File: rtl/serializer_rr_arbiter.sv
// Round-robin arbiter sharing one serializer between NUM_REQ parallel-word requesters.
// Optional watchdog on the serializer start handshake: define SER_ARB_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | serializer free; grant next requester and capture its word
// ISSUE      | present held word with ser_val_o until the serializer takes it
// WAIT_START | word handed off; waiting for ser_busy_i to rise
// WAIT_END   | burst in progress; waiting for ser_busy_i to fall
module serializer_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int TIMEOUT_CYC    = 4
) (
    input  logic                               clk_i,
    input  logic                               arst_ni,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]  req_data_i,
    input  logic [NUM_REQ*DATA_MOD_WIDTH-1:0]  req_mod_i,
    input  logic [NUM_REQ-1:0]                 req_val_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_REQ-1:0]                 req_drop_o,
    output logic [$clog2(NUM_REQ)-1:0]         grant_idx_o,
    output logic                               active_o,
    output logic [DATA_BUS_WIDTH-1:0]          ser_data_o,
    output logic [DATA_MOD_WIDTH-1:0]          ser_mod_o,
    output logic                               ser_val_o,
    input  logic                               ser_busy_i,
    output logic                               timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("serializer_rr_arbiter: NUM_REQ must be 2..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("serializer_rr_arbiter: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_END   = 2'd3
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            grant_idx;
    logic [DATA_BUS_WIDTH-1:0]   hold_data;
    logic [DATA_MOD_WIDTH-1:0]   hold_mod;
    logic [NUM_REQ-1:0]          drop_q;

    logic [DATA_BUS_WIDTH-1:0]   req_word [NUM_REQ];
    logic [DATA_MOD_WIDTH-1:0]   req_mod  [NUM_REQ];

    logic                        win_found;
    logic [IDX_W-1:0]            win_idx;
    logic [NUM_REQ-1:0]          win_onehot;
    logic                        grant;
    logic                        win_drop;
    int                          cand_sum;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_word[k] = req_data_i[k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
        assign req_mod[k]  = req_mod_i[k*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
    end

    // Search starts one past the last winner; explicit wrap keeps unused indices out
    // when NUM_REQ is not a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_sum = int'(rr_ptr) + i;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            if (!win_found && req_val_i[IDX_W'(cand_sum)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand_sum);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign grant      = (state == ST_IDLE) && !ser_busy_i && win_found;
    assign win_drop   = (req_mod[win_idx] == DATA_MOD_WIDTH'(1)) ||
                        (req_mod[win_idx] == DATA_MOD_WIDTH'(2));

    // Ready is combinational; gating with the reset keeps it low while reset is held.
    assign req_ready_o = (arst_ni && grant) ? win_onehot : '0;
    assign req_drop_o  = drop_q;
    assign grant_idx_o = grant_idx;
    assign active_o    = (state != ST_IDLE);
    assign ser_val_o   = (state == ST_ISSUE);
    assign ser_data_o  = hold_data;
    assign ser_mod_o   = hold_mod;

`ifdef SER_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
            hold_data <= '0;
            hold_mod  <= '0;
            drop_q    <= '0;
`ifdef SER_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            drop_q <= '0;
`ifdef SER_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        hold_data <= req_word[win_idx];
                        hold_mod  <= req_mod[win_idx];
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
                        if (win_drop) begin
                            drop_q <= win_onehot;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!ser_busy_i) begin
                        state <= ST_WAIT_START;
`ifdef SER_ARB_TIMEOUT_EN
                        to_cnt <= TO_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
                ST_WAIT_START: begin
                    if (ser_busy_i) begin
                        state <= ST_WAIT_END;
`ifdef SER_ARB_TIMEOUT_EN
                    end else if (to_cnt == '0) begin
                        // Serializer never started: abandon the word, keep rr_ptr.
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
`endif
                    end
                end
                ST_WAIT_END: begin
                    if (!ser_busy_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_rr_arbiter.sv
// Directed bench for serializer_rr_arbiter with a scoreboard of words expected at the serializer.
// Define SER_ARB_TIMEOUT_EN on both RTL and bench to exercise the watchdog variant.
module tb_serializer_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int M = 4;

    logic             clk_i = 1'b0;
    logic             arst_ni = 1'b0;
    logic [N*W-1:0]   req_data_i = '0;
    logic [N*M-1:0]   req_mod_i = '0;
    logic [N-1:0]     req_val_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0]     req_drop_o;
    logic [1:0]       grant_idx_o;
    logic             active_o;
    logic [W-1:0]     ser_data_o;
    logic [M-1:0]     ser_mod_o;
    logic             ser_val_o;
    logic             ser_busy_i = 1'b0;
    logic             timeout_o;

    serializer_rr_arbiter #(
        .NUM_REQ(N), .DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M), .TIMEOUT_CYC(4)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .req_data_i(req_data_i), .req_mod_i(req_mod_i), .req_val_i(req_val_i),
        .req_ready_o(req_ready_o), .req_drop_o(req_drop_o), .grant_idx_o(grant_idx_o),
        .active_o(active_o), .ser_data_o(ser_data_o), .ser_mod_o(ser_mod_o),
        .ser_val_o(ser_val_o), .ser_busy_i(ser_busy_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] d;
        logic [M-1:0] m;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] word_d [N];
    logic [M-1:0] word_m [N];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk_i);
    endtask

    task automatic set_req(input int k, input logic [W-1:0] d, input logic [M-1:0] m);
        req_data_i[k*W +: W] = d;
        req_mod_i[k*M +: M]  = m;
        word_d[k] = d;
        word_m[k] = m;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb_entry"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(ser_data_o), 32'(e.d));
            chk({tag, "_mod"},  32'(ser_mod_o),  32'(e.m));
        end
    endtask

    // Called in the IDLE cycle of a grant; runs a normal burst and returns in the next IDLE cycle.
    task automatic finish_grant(input int idx, input logic [N-1:0] nval);
        next(); req_val_i = nval; #1;
        chk("issue_val", 32'(ser_val_o), 1);
        chk("issue_gidx", 32'(grant_idx_o), 32'(idx));
        chk("issue_ready", 32'(req_ready_o), 0);
        chk("issue_drop", 32'(req_drop_o), 0);
        pop_chk("issue");
        next(); ser_busy_i = 1'b1; #1;
        chk("ws_val", 32'(ser_val_o), 0);
        chk("ws_active", 32'(active_o), 1);
        next(); #1;
        chk("we_ready_busy", 32'(req_ready_o), 0);
        next(); ser_busy_i = 1'b0; #1;
        chk("we_ready_fall", 32'(req_ready_o), 0);
        chk("we_active", 32'(active_o), 1);
        next(); #1;
        chk("idle_active", 32'(active_o), 0);
    endtask

    task automatic serve_one(input int idx, input logic [N-1:0] nval);
        chk("grant_ready", 32'(req_ready_o), 32'(1 << idx));
        sb.push_back({word_d[idx], word_m[idx]});
        finish_grant(idx, nval);
    endtask

    initial begin
        // Reset: outputs zero, ready held low even with requests pending.
        for (int k = 0; k < N; k++) set_req(k, 16'h0, 4'h0);
        req_val_i = '1;
        next(); next(); #1;
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_active", 32'(active_o), 0);
        chk("rst_ser_data", 32'(ser_data_o), 0);
        chk("rst_ser_val", 32'(ser_val_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);

        // Single request on requester 1.
        next();
        arst_ni = 1'b1;
        set_req(1, 16'hA5C3, 4'd0);
        req_val_i = 4'b0010;
        #1;
        serve_one(1, 4'b0000);

        // Requester 2 dropped (mod 1), requester 3 served next IDLE cycle.
        set_req(2, 16'h1234, 4'd1);
        set_req(3, 16'h5678, 4'd0);
        req_val_i = 4'b1100;
        #1;
        chk("drop_ready", 32'(req_ready_o), 32'(4'b0100));
        next(); req_val_i = 4'b1000; #1;
        chk("drop_pulse", 32'(req_drop_o), 32'(4'b0100));
        chk("drop_ser_val", 32'(ser_val_o), 0);
        chk("drop_active", 32'(active_o), 0);
        serve_one(3, 4'b0000);

        // All valid: round-robin order 0,1,2,3,0.
        set_req(0, 16'h1111, 4'd0);
        set_req(1, 16'h2222, 4'd3);
        set_req(2, 16'h3333, 4'd4);
        set_req(3, 16'h4444, 4'd15);
        req_val_i = 4'b1111;
        #1;
        serve_one(0, 4'b1111);
        serve_one(1, 4'b1111);
        serve_one(2, 4'b1111);
        serve_one(3, 4'b1111);
        serve_one(0, 4'b0000);

        // Busy in IDLE blocks grant; busy on ISSUE entry holds ser_val_o.
        ser_busy_i = 1'b1;
        set_req(1, 16'hBEEF, 4'd7);
        req_val_i = 4'b0010;
        #1;
        chk("busy_idle_ready", 32'(req_ready_o), 0);
        next(); #1;
        chk("busy_idle_ready2", 32'(req_ready_o), 0);
        chk("busy_idle_active", 32'(active_o), 0);
        ser_busy_i = 1'b0; #1;
        chk("busy_rel_ready", 32'(req_ready_o), 32'(4'b0010));
        sb.push_back({word_d[1], word_m[1]});
        next(); ser_busy_i = 1'b1; req_val_i = '0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_val", 32'(ser_val_o), 1);
            chk("hold_ready", 32'(req_ready_o), 0);
            next(); #1;
        end
        ser_busy_i = 1'b0; #1;
        chk("hold_val_accept", 32'(ser_val_o), 1);
        pop_chk("hold");
        next(); #1;
        chk("hold_single", 32'(ser_val_o), 0);
        chk("hold_ws_active", 32'(active_o), 1);
        ser_busy_i = 1'b1;
        next(); #1;
        next(); ser_busy_i = 1'b0; #1;
        next(); #1;
        chk("hold_idle", 32'(active_o), 0);

        // Reset during WAIT_END abandons the word; pointer restarts at requester 0.
        set_req(2, 16'hFFFF, 4'd0);
        req_val_i = 4'b0100;
        #1;
        chk("rstmid_ready", 32'(req_ready_o), 32'(4'b0100));
        sb.push_back({word_d[2], word_m[2]});
        next(); req_val_i = '0; #1;
        pop_chk("rstmid_issue");
        next(); ser_busy_i = 1'b1; #1;
        next(); #1;
        chk("rstmid_we_active", 32'(active_o), 1);
        arst_ni = 1'b0; #1;
        chk("rstmid_ready0", 32'(req_ready_o), 0);
        chk("rstmid_drop0", 32'(req_drop_o), 0);
        chk("rstmid_gidx0", 32'(grant_idx_o), 0);
        chk("rstmid_active0", 32'(active_o), 0);
        chk("rstmid_data0", 32'(ser_data_o), 0);
        chk("rstmid_mod0", 32'(ser_mod_o), 0);
        chk("rstmid_val0", 32'(ser_val_o), 0);
        chk("rstmid_to0", 32'(timeout_o), 0);
        next(); next();
        arst_ni = 1'b1;
        ser_busy_i = 1'b0;
        set_req(0, 16'h0C0C, 4'd5);
        req_val_i = 4'b1111;
        #1;
        serve_one(0, 4'b0000);

        // Serializer never starts after issue.
        set_req(1, 16'h0F0F, 4'd0);
        req_val_i = 4'b0010;
        #1;
        chk("to_ready", 32'(req_ready_o), 32'(4'b0010));
        sb.push_back({word_d[1], word_m[1]});
        next(); req_val_i = '0; #1;
        pop_chk("to_issue");
        next(); #1;
`ifdef SER_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_pending", 32'(timeout_o), 0);
            chk("to_active", 32'(active_o), 1);
            next(); #1;
        end
        chk("to_pulse", 32'(timeout_o), 1);
        chk("to_idle", 32'(active_o), 0);
        next(); #1;
        chk("to_pulse_end", 32'(timeout_o), 0);
`else
        for (int i = 0; i < 10; i++) begin
            chk("nto_timeout", 32'(timeout_o), 0);
            chk("nto_active", 32'(active_o), 1);
            chk("nto_val", 32'(ser_val_o), 0);
            next(); #1;
        end
        ser_busy_i = 1'b1;
        next(); ser_busy_i = 1'b0; #1;
        next(); #1;
        chk("nto_idle", 32'(active_o), 0);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
